// File: rtl/rx_data_sampler.sv
// UART RX oversampling front end: edge counter, three-point mid-bit sampling, majority vote.
// Optional noise flag enabled by defining SAMP_NOISE_FLAG_EN.
module rx_data_sampler #(
   parameter int PRESCALE_W = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx_in,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  dat_samp_en,
   output logic                  samp_data_in,
   output logic                  samp_valid,
   output logic                  bit_done,
   output logic [PRESCALE_W-1:0] edge_cnt,
   output logic                  samp_noise
);

   // Ratios below 4 leave no room for three samples; odd ratios have no exact mid-bit.
   function automatic logic [PRESCALE_W-1:0] sat_ps(input logic [PRESCALE_W-1:0] p);
      logic [PRESCALE_W-1:0] r;
      r    = p;
      r[0] = 1'b0;
      if (p < PRESCALE_W'(4)) begin
         r = PRESCALE_W'(4);
      end
      return r;
   endfunction

   function automatic logic vote3(input logic a, input logic b, input logic c);
      return (a & b) | (b & c) | (a & c);
   endfunction

   logic                  en_q;
   logic [PRESCALE_W-1:0] ps_q,    ps_d;
   logic [PRESCALE_W-1:0] edge_q,  edge_d;
   logic                  s0_q,    s0_d;
   logic                  s1_q,    s1_d;
   logic                  data_q,  data_d;
   logic                  valid_q, valid_d;
   logic                  done_q,  done_d;

   logic                  en_rise;
   logic [PRESCALE_W-1:0] ps_eff;
   logic [PRESCALE_W-1:0] mid;
   logic                  at_m1, at_mid, at_p1, at_last;

   // On the enable-rise cycle the counter already runs, so use the incoming ratio directly.
   always_comb begin
      en_rise = dat_samp_en & ~en_q;
      ps_eff  = en_rise ? sat_ps(prescale) : ps_q;
      mid     = ps_eff >> 1;
      at_m1   = (edge_q == mid - PRESCALE_W'(1));
      at_mid  = (edge_q == mid);
      at_p1   = (edge_q == mid + PRESCALE_W'(1));
      at_last = (edge_q == ps_eff - PRESCALE_W'(1));
   end

   always_comb begin
      ps_d    = ps_eff;
      edge_d  = '0;
      s0_d    = s0_q;
      s1_d    = s1_q;
      data_d  = data_q;
      valid_d = 1'b0;
      done_d  = 1'b0;
      if (dat_samp_en) begin
         edge_d  = at_last ? '0 : edge_q + PRESCALE_W'(1);
         done_d  = at_last;
         valid_d = at_p1;
         if (at_m1) begin
            s0_d = rx_in;
         end
         if (at_mid) begin
            s1_d = rx_in;
         end
         // Third sample is voted straight from the line so the strobe lands one clock later.
         if (at_p1) begin
            data_d = vote3(s0_q, s1_q, rx_in);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q    <= 1'b0;
         ps_q    <= PRESCALE_W'(8);
         edge_q  <= '0;
         s0_q    <= 1'b1;
         s1_q    <= 1'b1;
         data_q  <= 1'b1;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         en_q    <= dat_samp_en;
         ps_q    <= ps_d;
         edge_q  <= edge_d;
         s0_q    <= s0_d;
         s1_q    <= s1_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

`ifdef SAMP_NOISE_FLAG_EN
   logic noise_q, noise_d;

   always_comb begin
      noise_d = 1'b0;
      if (dat_samp_en && at_p1) begin
         noise_d = !((s0_q == s1_q) && (s1_q == rx_in));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         noise_q <= 1'b0;
      end else begin
         noise_q <= noise_d;
      end
   end

   assign samp_noise = noise_q;
`else
   assign samp_noise = 1'b0;
`endif

   assign samp_data_in = data_q;
   assign samp_valid   = valid_q;
   assign bit_done     = done_q;
   assign edge_cnt     = edge_q;

endmodule

// File: tb/tb_rx_data_sampler.sv
// Bench for rx_data_sampler: run-length/history model checked every cycle plus directed literal checks.
module tb_rx_data_sampler;
   localparam int PW = 6;
`ifdef SAMP_NOISE_FLAG_EN
   localparam bit NOISE_EN = 1'b1;
`else
   localparam bit NOISE_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          rx_in;
   logic [PW-1:0] prescale;
   logic          dat_samp_en;
   logic          samp_data_in, samp_valid, bit_done, samp_noise;
   logic [PW-1:0] edge_cnt;

   rx_data_sampler #(.PRESCALE_W(PW)) dut (
      .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .prescale(prescale),
      .dat_samp_en(dat_samp_en), .samp_data_in(samp_data_in), .samp_valid(samp_valid),
      .bit_done(bit_done), .edge_cnt(edge_cnt), .samp_noise(samp_noise)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
   endtask

   // ---------------- model: enabled run length + last three line values ----------------
   function automatic int sat(input int p);
      int r;
      r = p - (p % 2);
      if (p < 4) r = 4;
      return r;
   endfunction

   function automatic bit is_vote(input int r, input int ps);
      int m;
      m = ps / 2 + 2;
      return (r >= m) && ((r - m) % ps == 0);
   endfunction

   int       run;
   int       m_ps;
   logic [2:0] hist;
   logic     m_data, m_valid, m_done, m_noise;
   int       m_edge;
   int       ps_now;
   logic [2:0] win;

   always_comb begin
      ps_now = (run == 0) ? sat(int'(prescale)) : m_ps;
      win    = {hist[1:0], rx_in};
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run <= 0; m_ps <= 8; hist <= 3'b111;
         m_data <= 1'b1; m_valid <= 1'b0; m_done <= 1'b0; m_noise <= 1'b0; m_edge <= 0;
      end else if (dat_samp_en) begin
         run     <= run + 1;
         m_ps    <= ps_now;
         hist    <= win;
         m_edge  <= (run + 1) % ps_now;
         m_done  <= ((run + 1) % ps_now) == 0;
         m_valid <= is_vote(run + 1, ps_now);
         m_noise <= 1'b0;
         if (is_vote(run + 1, ps_now)) begin
            m_data  <= ($countones(win) >= 2);
            m_noise <= NOISE_EN && !(win == 3'b000 || win == 3'b111);
         end
      end else begin
         run <= 0; m_edge <= 0; m_valid <= 1'b0; m_done <= 1'b0; m_noise <= 1'b0;
      end
   end

   // ---------------- per-cycle compare and event capture ----------------
   logic vq[$];
   logic nq[$];
   int   dq[$];
   int   first_v;
   int   t_en;

   task automatic sample_outputs();
      if (rst_n === 1'b1) begin
         check("edge_cnt",     int'(edge_cnt),     m_edge);
         check("samp_valid",   int'(samp_valid),   int'(m_valid));
         check("bit_done",     int'(bit_done),     int'(m_done));
         check("samp_data_in", int'(samp_data_in), int'(m_data));
         check("samp_noise",   int'(samp_noise),   int'(m_noise));
         if (samp_valid) begin
            vq.push_back(samp_data_in);
            nq.push_back(samp_noise);
            if (first_v < 0) first_v = cyc;
         end
         if (bit_done) dq.push_back(cyc);
      end
   endtask

   always @(negedge clk) sample_outputs();

   task automatic clear_q();
      vq.delete(); nq.delete(); dq.delete(); first_v = -1;
   endtask

   task automatic frame(input int ps, input logic [7:0] bits, input int nb,
                        input int glitch_at, input int ps_mid);
      clear_q();
      prescale    = PW'(ps);
      dat_samp_en = 1'b1;
      t_en        = cyc;
      for (int j = 0; j < nb * sat(ps); j++) begin
         rx_in = bits[j / sat(ps)] ^ (j == glitch_at);
         if (ps_mid > 0 && j == 10) prescale = PW'(ps_mid);
         @(negedge clk);
      end
      dat_samp_en = 1'b0;
      rx_in       = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      first_v = -1;
      rst_n = 1'b0; dat_samp_en = 1'b0; rx_in = 1'b1; prescale = PW'(8);
      repeat (3) @(negedge clk);
      check("rst_edge",  int'(edge_cnt), 0);
      check("rst_data",  int'(samp_data_in), 1);
      check("rst_valid", int'(samp_valid), 0);
      check("rst_done",  int'(bit_done), 0);
      check("rst_noise", int'(samp_noise), 0);
      rst_n = 1'b1;
      clear_q();
      repeat (4) @(negedge clk);
      check("idle_edge",    int'(edge_cnt), 0);
      check("idle_strobes", vq.size() + dq.size(), 0);

      // clean bits at ratio 8: 0,1,0,1
      frame(8, 8'b0000_1010, 4, -1, 0);
      check("t2_nvotes", vq.size(), 4);
      check("t2_v0", int'(vq[0]), 0);
      check("t2_v1", int'(vq[1]), 1);
      check("t2_v2", int'(vq[2]), 0);
      check("t2_v3", int'(vq[3]), 1);
      check("t2_vlat", first_v - t_en, 6);
      check("t2_ndone", dq.size(), 4);
      check("t2_dlat", dq[0] - t_en, 8);
      check("t2_dper", dq[3] - dq[2], 8);

      // glitch at edge 7 of a ratio-16 one bit
      frame(16, 8'b0000_0001, 1, 7, 0);
      check("t3_nvotes", vq.size(), 1);
      check("t3_vote", int'(vq[0]), 1);
      check("t3_noise", int'(nq[0]), NOISE_EN ? 1 : 0);
      check("t3_vlat", first_v - t_en, 10);

      // ratio 32 latched; prescale rewritten to 8 mid-frame
      frame(32, 8'b0000_0011, 2, -1, 8);
      check("t4_ndone", dq.size(), 2);
      check("t4_dlat", dq[0] - t_en, 32);
      check("t4_dper", dq[1] - dq[0], 32);
      frame(8, 8'b0000_0000, 1, -1, 0);
      check("t4_relatch", dq[0] - t_en, 8);
      check("t4_vote", int'(vq[0]), 0);

      // enable dropped at edge 3
      clear_q();
      prescale = PW'(8); rx_in = 1'b1; dat_samp_en = 1'b1;
      repeat (3) @(negedge clk);
      check("t5_edge3", int'(edge_cnt), 3);
      dat_samp_en = 1'b0;
      @(negedge clk);
      check("t5_clear", int'(edge_cnt), 0);
      @(negedge clk);
      check("t5_novote", vq.size(), 0);
      check("t5_hold", int'(samp_data_in), 0);

      // enable dropped in the vote cycle (edge mid+1)
      dat_samp_en = 1'b1;
      repeat (5) @(negedge clk);
      check("t5b_edge5", int'(edge_cnt), 5);
      dat_samp_en = 1'b0;
      repeat (3) @(negedge clk);
      check("t5b_novote", vq.size(), 0);
      check("t5b_hold", int'(samp_data_in), 0);

      // ratio 2 forced to 4; edge 0 of bit 0 is low but not sampled
      frame(2, 8'b0000_0001, 2, 0, 0);
      check("t6_dlat", dq[0] - t_en, 4);
      check("t6_dper", dq[1] - dq[0], 4);
      check("t6_vlat", first_v - t_en, 4);
      check("t6_v0", int'(vq[0]), 1);
      check("t6_v1", int'(vq[1]), 0);
      check("t6_noise", int'(nq[0]), 0);

      // async reset mid-count
      prescale = PW'(8); rx_in = 1'b1; dat_samp_en = 1'b1;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t1_edge", int'(edge_cnt), 0);
      check("t1_data", int'(samp_data_in), 1);
      check("t1_valid", int'(samp_valid), 0);
      check("t1_done", int'(bit_done), 0);
      @(negedge clk);
      dat_samp_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      clear_q();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t1_rel_edge", int'(edge_cnt), 0);
         check("t1_rel_strb", int'(samp_valid | bit_done), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
